// File: rtl/perf_counter_reader_if.sv
// Bundle between the counter bank / host read path and perf_counter_reader.
// Signal suffixes are from the reader's point of view (slave modport).
interface perf_counter_reader_if #(
    parameter int NUM_COUNTERS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int IDX_WIDTH    = 2
);
    logic                               snap_req_i;
    logic [NUM_COUNTERS*DATA_WIDTH-1:0] cnt_in_i;
    logic                               rd_ready_i;
    logic                               cnt_clr_o;
    logic                               busy_o;
    logic                               rd_valid_o;
    logic [DATA_WIDTH-1:0]              rd_data_o;
    logic [IDX_WIDTH-1:0]               rd_idx_o;
    logic                               rd_last_o;
    logic                               snap_dropped_o;

    modport slave (
        input  snap_req_i,
        input  cnt_in_i,
        input  rd_ready_i,
        output cnt_clr_o,
        output busy_o,
        output rd_valid_o,
        output rd_data_o,
        output rd_idx_o,
        output rd_last_o,
        output snap_dropped_o
    );

    modport master (
        output snap_req_i,
        output cnt_in_i,
        output rd_ready_i,
        input  cnt_clr_o,
        input  busy_o,
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_idx_o,
        input  rd_last_o,
        input  snap_dropped_o
    );
endinterface

// File: rtl/perf_counter_reader.sv
// Snapshots the perf-counter bank into shadow registers in one cycle, optionally
// clears the counters, then streams the frozen values one per valid/ready beat.
module perf_counter_reader #(
    parameter int NUM_COUNTERS  = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int IDX_WIDTH     = 2,
    parameter int CLEAR_ON_SNAP = 1
) (
    input  logic clk,
    input  logic rst,
    perf_counter_reader_if.slave bus
);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   cnt_clr_q, cnt_clr_d;
    logic                   dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0]  shadow_q [NUM_COUNTERS];
    logic                   capture;
    logic                   is_last;
    logic                   xfer;

    assign is_last = (idx_q == IDX_WIDTH'(NUM_COUNTERS - 1));
    assign xfer    = (state_q == SEND) && bus.rd_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_clr_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_clr_q <= cnt_clr_d;
            dropped_q <= dropped_d;
        end
    end

    // A request landing on the final beat restarts the stream with no idle gap.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_clr_d = 1'b0;
        dropped_d = dropped_q;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.snap_req_i) begin
                    capture = 1'b1;
                end
            end
            SEND: begin
                if (xfer && is_last) begin
                    if (bus.snap_req_i) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                    if (bus.snap_req_i) begin
                        dropped_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (capture) begin
            state_d   = SEND;
            idx_d     = '0;
            dropped_d = 1'b0;
            cnt_clr_d = (CLEAR_ON_SNAP != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow_q[i] <= bus.cnt_in_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.busy_o         = (state_q == SEND);
    assign bus.rd_valid_o     = (state_q == SEND);
    assign bus.rd_data_o      = shadow_q[idx_q];
    assign bus.rd_idx_o       = idx_q;
    assign bus.rd_last_o      = (state_q == SEND) && is_last;
    assign bus.cnt_clr_o      = cnt_clr_q;
    assign bus.snap_dropped_o = dropped_q;

endmodule
